// File: rtl/run_length_pkg.sv
// Shared types and defaults for the run-length serial transmitter.
package run_length_pkg;

   localparam int LEN_W_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ONES = 2'd1,
      TERM = 2'd2
   } rl_state_t;

endpackage

// File: rtl/run_length_down_counter.sv
// Loadable down-counter that tracks the ones still to send and flags the final one.
module run_length_down_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         is_one
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign is_one = (cnt_q == W'(1));

endmodule

// File: rtl/run_length_bit_tx.sv
// Serialises run descriptors as N ones plus one terminating zero, and predicts
// the downstream consecutive-ones detector output from a two-deep bit history.
module run_length_bit_tx #(
   parameter int LEN_W = run_length_pkg::LEN_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_valid,
   input  logic [LEN_W-1:0] run_len,
   output logic             run_ready,
   output logic             out,
   output logic             out_valid,
   output logic             busy,
   output logic             exp_det
);
   import run_length_pkg::*;

   rl_state_t state_q;
   rl_state_t state_d;
   logic      accept;
   logic      len_nz;
   logic      cnt_load;
   logic      cnt_dec;
   logic      cnt_is_one;
   logic      h1_q;
   logic      h1_d;
   logic      h2_q;
   logic      h2_d;

   assign accept = run_valid && run_ready;
   assign len_nz = (run_len != '0);

   // Counter only ever holds a value while in ONES, so it never reaches zero there.
   assign cnt_load = accept && len_nz;
   assign cnt_dec  = (state_q == ONES) && !cnt_is_one;

   run_length_down_counter #(
      .W (LEN_W)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (run_len),
      .dec      (cnt_dec),
      .is_one   (cnt_is_one)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, TERM: begin
            if (accept) begin
               state_d = len_nz ? ONES : TERM;
            end else begin
               state_d = IDLE;
            end
         end
         ONES: begin
            if (cnt_is_one) begin
               state_d = TERM;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out       = (state_q == ONES);
      out_valid = (state_q != IDLE);
      busy      = (state_q != IDLE);
      run_ready = (state_q != ONES);
   end

   // Detector sees two consecutive ones one cycle after the second of them.
   assign h1_d    = out;
   assign h2_d    = h1_q;
   assign exp_det = h1_q & h2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         h1_q    <= 1'b0;
         h2_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         h1_q    <= h1_d;
         h2_q    <= h2_d;
      end
   end

endmodule

// File: tb/tb_run_length_bit_tx.sv
// Bench for run_length_bit_tx: directed vector table, multi-cycle corner sequences,
// and randomized descriptors checked against a bit-queue reference model.
module tb_run_length_bit_tx;

   logic       clk;
   logic       rst;
   logic       run_valid;
   logic [3:0] run_len;
   logic       run_ready;
   logic       out;
   logic       out_valid;
   logic       busy;
   logic       exp_det;

   int errors;
   int checks;

   run_length_bit_tx #(
      .LEN_W (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .run_valid (run_valid),
      .run_len   (run_len),
      .run_ready (run_ready),
      .out       (out),
      .out_valid (out_valid),
      .busy      (busy),
      .exp_det   (exp_det)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected vector packs {run_ready, out, out_valid, busy, exp_det}.
   typedef struct {
      bit         rst;
      bit         vld;
      logic [3:0] len;
      logic [4:0] exp;
   } vec_t;

   vec_t vec [16];

   function automatic logic [4:0] obs();
      return {run_ready, out, out_valid, busy, exp_det};
   endfunction

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got {rdy,out,ov,busy,det}=%b required %b", name, act, expv);
      end
   endtask

   task automatic check_int(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", name, act, expv);
      end
   endtask

   task automatic step(input bit r, input bit v, input logic [3:0] l);
      rst       = r;
      run_valid = v;
      run_len   = l;
      @(posedge clk);
      #1;
   endtask

   // Reference model: queue of bits still to appear on the line (head = current cycle).
   bit mq[$];
   int ones_before;

   initial begin
      int   det_cnt;
      bit   r;
      bit   v;
      logic [3:0] l;
      bit   pending;
      bit   acc;
      bit   m_ready;
      bit   m_out;
      logic [4:0] m_exp;

      errors    = 0;
      checks    = 0;
      rst       = 1'b1;
      run_valid = 1'b0;
      run_len   = '0;

      vec = '{
         '{1'b1, 1'b0, 4'd0, 5'b10000},
         '{1'b1, 1'b0, 4'd0, 5'b10000},
         '{1'b0, 1'b1, 4'd3, 5'b01110},
         '{1'b0, 1'b0, 4'd0, 5'b01110},
         '{1'b0, 1'b0, 4'd0, 5'b01111},
         '{1'b0, 1'b0, 4'd0, 5'b10111},
         '{1'b0, 1'b0, 4'd0, 5'b10000},
         '{1'b0, 1'b1, 4'd0, 5'b10110},
         '{1'b0, 1'b1, 4'd1, 5'b01110},
         '{1'b0, 1'b1, 4'd2, 5'b10110},
         '{1'b0, 1'b1, 4'd2, 5'b01110},
         '{1'b0, 1'b0, 4'd0, 5'b01110},
         '{1'b0, 1'b0, 4'd0, 5'b10111},
         '{1'b0, 1'b0, 4'd0, 5'b10000},
         '{1'b1, 1'b1, 4'd3, 5'b10000},
         '{1'b0, 1'b0, 4'd0, 5'b10000}
      };

      for (int i = 0; i < 16; i++) begin
         step(vec[i].rst, vec[i].vld, vec[i].len);
         check($sformatf("vec%0d", i), obs(), vec[i].exp);
      end

      // Maximum run of 15 ones from IDLE.
      step(1'b0, 1'b1, 4'd15);
      det_cnt = 0;
      for (int c = 1; c <= 16; c++) begin
         check($sformatf("max_run_c%0d", c), obs(),
               {c == 16, c <= 15, 1'b1, 1'b1, c >= 3});
         if (exp_det) det_cnt++;
         if (c < 16) step(1'b0, 1'b0, 4'd0);
      end
      check_int("max_run_det_cycles", det_cnt, 14);
      step(1'b0, 1'b0, 4'd0);
      check("max_run_idle", obs(), 5'b10000);

      // Reset during the second ONES cycle of a length-5 run.
      step(1'b0, 1'b1, 4'd5);
      check("midrst_ones1", obs(), 5'b01110);
      step(1'b0, 1'b0, 4'd0);
      check("midrst_ones2", obs(), 5'b01110);
      step(1'b1, 1'b0, 4'd0);
      check("midrst_after_rst", obs(), 5'b10000);
      step(1'b0, 1'b0, 4'd0);
      check("midrst_no_term", obs(), 5'b10000);
      step(1'b0, 1'b0, 4'd0);
      check("midrst_idle", obs(), 5'b10000);

      // Randomized descriptors against the queue model.
      mq.delete();
      ones_before = 0;
      pending = 1'b0;
      v = 1'b0;
      l = '0;
      for (int i = 0; i < 10000; i++) begin
         r = (i < 2) || ($urandom_range(0, 299) == 0);
         if (!pending) begin
            v = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0)
               l = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'd15;
            else
               l = 4'($urandom_range(0, 15));
         end
         m_ready = (mq.size() <= 1);
         m_out   = (mq.size() > 0) ? mq[0] : 1'b0;
         acc     = v && m_ready && !r;
         step(r, v, l);
         if (r) begin
            mq.delete();
            ones_before = 0;
         end else begin
            ones_before = m_out ? ones_before + 1 : 0;
            if (mq.size() > 0) void'(mq.pop_front());
            if (acc) begin
               repeat (l) mq.push_back(1'b1);
               mq.push_back(1'b0);
            end
         end
         pending = v && !acc && !r;
         m_exp = {mq.size() <= 1, (mq.size() > 0) ? mq[0] : 1'b0,
                  mq.size() > 0, mq.size() > 0, ones_before >= 2};
         check($sformatf("rand_c%0d", i), obs(), m_exp);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/run_length_bit_tx.md
Name: run_length_bit_tx

Overview:
- Transmit-side counterpart to the team's serial "consecutive 1s" Moore detector.
- Accepts run descriptors over a valid/ready handshake and serialises each one onto a single-bit line. A descriptor of length N produces N ones followed by exactly one terminating zero.
- Drives the detector's serial input directly. It also produces `exp_det`, a cycle-aligned prediction of the detector's output, for checking.

Parameters:
- LEN_W, 4: width of the run length field; maximum run is 2^LEN_W-1 ones.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- run_valid  in  1  descriptor present.
- run_len  in  LEN_W  number of 1s in the run (0 is legal).
- run_ready  out  1  block can accept a descriptor this cycle.
- out  out  1  serial bit to the detector.
- out_valid  out  1  `out` carries descriptor data (0 = idle filler).
- busy  out  1  a run is in progress (state is not IDLE).
- exp_det  out  1  predicted detector output for the current cycle.

Behaviour:
- Interface:
  - One clock, `clk`. Reset `rst` is synchronous and active-high.
  - While `rst` is high at a rising edge: state goes to IDLE, the counter clears, and the history registers clear.
  - Reset values: run_ready=1, out=0, out_valid=0, busy=0, exp_det=0.
- Handshake:
  - A descriptor is accepted on a rising edge where run_valid && run_ready.
  - run_len is sampled only at acceptance.
  - run_ready is a Moore decode of state: 1 in IDLE and in TERM, 0 in ONES.
  - The source must hold run_valid and run_len stable until accepted.
- States (enum in package) and outputs:
  - IDLE: out=0, out_valid=0.
  - ONES: out=1, out_valid=1.
  - TERM: out=0, out_valid=1.
  - out, out_valid and busy are decoded from registered state only; no input-to-output combinational path.
- Transitions:
  - IDLE, accept with run_len>0 -> ONES, cnt<=run_len.
  - IDLE, accept with run_len==0 -> TERM.
  - IDLE, no accept -> IDLE.
  - ONES, cnt>1 -> ONES, cnt<=cnt-1.
  - ONES, cnt==1 -> TERM.
  - TERM, accept -> ONES or TERM by the same run_len rule as IDLE.
  - TERM, no accept -> IDLE.
- Latency:
  - First bit of a descriptor accepted at edge t appears in the cycle following t.
  - A run of N occupies exactly N+1 out_valid cycles.
  - Back-to-back descriptors (accepted in TERM) produce no idle gap.
- Counter: LEN_W bits, down-counting. The ONES state guarantees cnt>=1, so the counter never wraps.
- exp_det:
  - Registered history h1 = out of the previous cycle, h2 = out two cycles back.
  - exp_det = h1 & h2. This matches the detector's Moore output for the same stream.
  - For a run of N>=2, exp_det is high for N-1 cycles, starting 2 cycles after the first 1.
  - For N<=1, exp_det stays 0.
  - Terminator zeros guarantee runs never merge across descriptors.
- Maximum run: run_len = 2^LEN_W-1 gives 15 ones (default) and no overflow.
- Reset mid-run:
  - The partial run is abandoned, with no terminator emitted.
  - Outputs return to reset values in the cycle after the reset edge.
  - A descriptor presented during reset is not accepted.

Decomposition:
- Package run_length_pkg holds:
  - typedef enum logic [1:0] {IDLE, ONES, TERM} rl_state_t;
  - default LEN_W localparam.
- Optional sub-module run_length_down_counter (load, decrement, count==1 flag). Inlining it is acceptable.

Test Plan:
- Apply rst for 2 cycles -> run_ready=1, out=0, out_valid=0, busy=0, exp_det=0.
- Send one descriptor run_len=3 accepted at edge t -> out = 1,1,1,0 in cycles t+1..t+4, with out_valid high for those 4 cycles; exp_det high in t+3..t+4 only; IDLE at t+5.
- Send run_len=0, then run_len=1 back-to-back -> out = 0,1,0 contiguous with out_valid continuously 1; exp_det never asserts.
- Send run_len=15 (LEN_W=4) -> 15 ones then one zero, 16 valid cycles; exp_det high for 14 cycles; run_ready low for cycles 1-15.
- Assert rst in the 2nd ONES cycle of a run_len=5 descriptor -> the following cycle shows out=0, out_valid=0, busy=0, exp_det=0, and no terminator.
- Run random descriptors feeding the detector instance; compare the detector output against exp_det every cycle -> zero mismatches over 10k cycles.
